instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that generates sequential PCs, issues requests to instruction memory over a valid/ready handshake and buffers in-order responses in a prefetch queue.
- Presents {instr, instr_pc} to the decode/register-file stage through a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 4, prefetch queue entries. Must be a power of 2 and at least 2; also the cap on in-flight plus buffered instructions.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses arrive in request order, at most one per cycle.
- imem_rsp_data  in  XLEN  fetched instruction word.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  downstream accepts the head.
- instr  out  XLEN  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0; imem_req_valid=0; instr_valid=0; instr=0; instr_pc=0. Reset overrides every other input in the same cycle, including a redirect.
- Request issue:
  - imem_req_valid=1 when not in reset, redirect_valid=0, and outstanding + occupancy < QDEPTH.
  - imem_req_addr=fetch_pc.
  - On handshake (valid & ready): fetch_pc <= fetch_pc+4, wrapping mod 2^XLEN (32'hFFFF_FFFC -> 0); outstanding increments.
  - Address and valid hold stable while valid=1 and ready=0.
- First request: imem_req_valid=1 with addr=RESET_PC in the first cycle after rst deasserts.
- Response handling:
  - On imem_rsp_valid, outstanding decrements.
  - If discard>0, the response is dropped and discard decrements.
  - Otherwise {rsp_data, pc} is written at the tail; the pc comes from a request-PC tracker advancing in step with accepted requests.
  - A response with outstanding==0 is ignored.
  - The credit rule above guarantees the queue never overflows.
- Output:
  - instr_valid = queue not empty.
  - instr/instr_pc are driven from the registered head entry.
  - Minimum latency from rsp_valid to instr_valid is 1 cycle.
  - On instr_valid & instr_ready the head pops.
  - Push and pop in the same cycle are allowed, including when the queue is full (occupancy unchanged) and when it is empty (the pushed entry is visible next cycle).
- Redirect (redirect_valid=1):
  - No request is issued that cycle.
  - Next cycle: fetch_pc=redirect_pc & ~3; queue emptied; discard = outstanding after this cycle's response accounting.
  - A pop handshake in the redirect cycle completes normally.
  - A response arriving in the redirect cycle is dropped.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
  - First new request goes out in the cycle after the redirect.
- Counters: outstanding and discard are each log2(QDEPTH)+1 bits and never wrap. Occupancy uses a read/write pointer pair with an extra wrap bit.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined: adds outputs perf_fetched (32-bit, count of accepted pops), perf_redirects (32-bit, count of redirect cycles) and perf_stall (32-bit, cycles with instr_valid=0 outside reset).
  - All three reset to 0 and wrap at 2^32.
- When undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then memory always ready with 1-cycle response latency, instr_ready=1 -> request addrs 0x0, 0x4, 0x8, ... on consecutive cycles; instr_pc sequence 0x0, 0x4, 0x8 with the matching data.
- instr_ready=0 for 10 cycles -> exactly QDEPTH=4 requests issued, then imem_req_valid=0; queue full. Releasing ready drains 4 instructions in order, then fetch resumes at 0x10.
- Memory response latency 3 cycles; redirect_pc=0x103 with 2 requests in flight -> 2 stale responses dropped; next request addr 0x100; first delivered instr_pc=0x100.
- imem_req_ready=0 for 5 cycles with fetch_pc=0x20 -> imem_req_addr holds 0x20 and imem_req_valid stays 1.
- RESET_PC=32'hFFFF_FFF8 -> request addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).
- Assert rst mid-stream with 3 queued and 1 outstanding -> next cycle instr_valid=0, outputs 0, first request at RESET_PC; with IFU_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage with prefetch queue.
//
// The unit generates sequential fetch PCs and issues them to instruction memory
// over a valid/ready handshake. It buffers in-order responses, tagged with their
// PCs, in a small prefetch queue. The queue head goes to decode over a second
// valid/ready handshake. A redirect flushes the queue, restarts fetch at the
// target, and marks every request still in flight as stale so that its response
// is dropped.
//
// Optional feature: when the macro IFU_PERF_CNT_EN is defined, the unit adds
// three 32-bit performance counters: perf_fetched, perf_redirects and perf_stall.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   in-order response valid (at most one per cycle)
//   imem_rsp_data   in   fetched instruction word
//   redirect_valid  in   branch/jump redirect
//   redirect_pc     in   redirect target (bits [1:0] ignored)
//   instr_valid     out  queue head valid
//   instr_ready     in   downstream accepts the head
//   instr           out  head instruction
//   instr_pc        out  PC of the head instruction
//   perf_*          out  performance counters (IFU_PERF_CNT_EN only)
//
// QDEPTH must be a power of 2 and at least 2.

module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_redirects,
   output logic [31:0]     perf_stall
`endif
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] q_data [QDEPTH];
   logic [XLEN-1:0] q_pc   [QDEPTH];

   logic [CW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [XLEN-1:0] fetch_pc_q;
   // PC of the next response that will be kept; only advances on a push.
   logic [XLEN-1:0] rsp_pc_q;

   logic [CW-1:0]   occupancy;
   logic [CW:0]     credit_used;
   logic            req_hs, rsp_take, rsp_drop, push, pop;
   logic [XLEN-1:0] redirect_target;

   // The low two bits of the redirect target are not used.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

   always_comb begin
      occupancy   = wptr_q - rptr_q;
      // Queue slots are reserved for every in-flight request, so a push never overflows.
      credit_used = {1'b0, outstanding_q} + {1'b0, occupancy};

      imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(QDEPTH));
      imem_req_addr  = fetch_pc_q;
      req_hs         = imem_req_valid && imem_req_ready;

      // Responses with nothing outstanding are spurious and are ignored entirely.
      rsp_take = imem_rsp_valid && (outstanding_q != '0);
      rsp_drop = rsp_take && (redirect_valid || (discard_q != '0));
      push     = rsp_take && !rsp_drop;

      instr_valid = (occupancy != '0);
      pop         = instr_valid && instr_ready;
      instr       = instr_valid ? q_data[rptr_q[AW-1:0]] : '0;
      instr_pc    = instr_valid ? q_pc[rptr_q[AW-1:0]]   : '0;

      outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_take);

      // On a redirect, every request still in flight after this cycle is stale.
      if (redirect_valid) begin
         discard_d = outstanding_d;
      end else if (rsp_take && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end else begin
         discard_d = discard_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         wptr_q        <= '0;
         rptr_q        <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
            rsp_pc_q   <= redirect_target;
            wptr_q     <= '0;
            rptr_q     <= '0;
         end else begin
            if (req_hs) begin
               fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end
            if (push) begin
               wptr_q   <= wptr_q + CW'(1);
               rsp_pc_q <= rsp_pc_q + XLEN'(4);
            end
            if (pop) begin
               rptr_q <= rptr_q + CW'(1);
            end
         end
      end
   end

   // Queue storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         q_data[wptr_q[AW-1:0]] <= imem_rsp_data;
         q_pc[wptr_q[AW-1:0]]   <= rsp_pc_q;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_redirects_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_redirects_q <= '0;
         perf_stall_q     <= '0;
      end else begin
         if (pop) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (redirect_valid) begin
            perf_redirects_q <= perf_redirects_q + 32'd1;
         end
         if (!instr_valid) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_redirects = perf_redirects_q;
   assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit.
//
// The bench models memory as a queue of pending requests with a configurable
// latency. The reference model says that the requests, and the delivered
// instructions, must each form a sequential PC stream. Each stream restarts at
// the most recent redirect target. The data returned for any PC must equal a
// fixed hash of that PC.

module tb_instr_fetch_unit;

   localparam int unsigned QDEPTH = 4;

   logic        clk;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;

   logic        w_rst;
   logic        w_req_valid, w_req_ready;
   logic [31:0] w_req_addr;
   logic        w_rsp_valid;
   logic [31:0] w_rsp_data;
   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_instr_valid, w_instr_ready;
   logic [31:0] w_instr, w_instr_pc;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_redirects, perf_stall;
   logic [31:0] w_perf_fetched, w_perf_redirects, w_perf_stall;
`endif

   instr_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects),
      .perf_stall     (perf_stall)
`endif
   );

   instr_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'hFFFF_FFF8),
      .QDEPTH   (QDEPTH)
   ) dut_wrap (
      .clk            (clk),
      .rst            (w_rst),
      .imem_req_valid (w_req_valid),
      .imem_req_ready (w_req_ready),
      .imem_req_addr  (w_req_addr),
      .imem_rsp_valid (w_rsp_valid),
      .imem_rsp_data  (w_rsp_data),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .instr_valid    (w_instr_valid),
      .instr_ready    (w_instr_ready),
      .instr          (w_instr),
      .instr_pc       (w_instr_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetched   (w_perf_fetched),
      .perf_redirects (w_perf_redirects),
      .perf_stall     (w_perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   int          cyc;
   int          lat;
   logic [31:0] exp_pc, exp_req;
   int          live;
   int          n_pop, n_redir, n_stall;
   int          checks, errors;

   logic        s_req_valid, s_instr_valid, s_pop;
   logic [31:0] s_req_addr, s_instr_pc;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
   endfunction

   task automatic init_model();
      mem_q.delete();
      exp_pc  = 32'h0;
      exp_req = 32'h0;
      live    = 0;
      n_pop   = 0;
      n_redir = 0;
      n_stall = 0;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      init_model();
   endtask

   // One clock cycle: drive inputs at the falling edge, sample, run the model.
   task automatic cycle(input bit rq_rdy, input bit in_rdy, input bit redir,
                        input logic [31:0] tgt);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_f(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      imem_req_ready = rq_rdy;
      instr_ready    = in_rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      s_req_valid   = imem_req_valid;
      s_req_addr    = imem_req_addr;
      s_instr_valid = instr_valid;
      s_instr_pc    = instr_pc;
      s_pop         = instr_valid && in_rdy;

      checks++;
      if (redir && imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL req_in_redirect: cyc %0d req_valid=%b required 0", cyc, imem_req_valid);
      end
      if (imem_req_valid === 1'b1) begin
         checks++;
         if (imem_req_addr !== exp_req) begin
            errors++;
            $display("FAIL req_addr: cyc %0d got %h required %h", cyc, imem_req_addr, exp_req);
         end
         if (rq_rdy) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_req = exp_req + 32'd4;
            live++;
         end
      end
      if (s_pop) begin
         checks++;
         if (instr_pc !== exp_pc || instr !== mem_f(exp_pc)) begin
            errors++;
            $display("FAIL deliver: cyc %0d got pc %h instr %h required pc %h instr %h",
                     cyc, instr_pc, instr, exp_pc, mem_f(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
         live--;
         n_pop++;
      end
      if (redir) begin
         exp_pc  = {tgt[31:2], 2'b00};
         exp_req = {tgt[31:2], 2'b00};
         live    = 0;
         n_redir++;
      end
      if (instr_valid !== 1'b1) n_stall++;
      checks++;
      if (live > int'(QDEPTH)) begin
         errors++;
         $display("FAIL credit: cyc %0d live %0d allowed %0d", cyc, live, QDEPTH);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b instr=%h pc=%h required 0/0/0",
                  instr_valid, instr, instr_pc);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_req_valid: got %b required 0", imem_req_valid);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetched !== 32'h0 || perf_redirects !== 32'h0 || perf_stall !== 32'h0) begin
         errors++;
         $display("FAIL reset_perf: got %h %h %h required 0", perf_fetched, perf_redirects,
                  perf_stall);
      end
`endif
      rst            = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: got v=%b addr=%h required 1/00000000", imem_req_valid,
                  imem_req_addr);
      end
      init_model();
   endtask

   task automatic test_in_order();
      int nreq;
      do_reset();
      lat  = 1;
      nreq = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (s_req_valid) nreq++;
      end
      checks++;
      if (nreq != 12) begin
         errors++;
         $display("FAIL in_order_rate: got %0d requests required 12", nreq);
      end
      checks++;
      if (n_pop < 9) begin
         errors++;
         $display("FAIL in_order_pops: got %0d required >= 9", n_pop);
      end
   endtask

   task automatic test_backpressure();
      int          nreq, pops;
      bit          got;
      logic [31:0] first;
      do_reset();
      lat  = 1;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0);
         if (s_req_valid) nreq++;
      end
      checks++;
      if (nreq != int'(QDEPTH)) begin
         errors++;
         $display("FAIL bp_req_count: got %0d required %0d", nreq, QDEPTH);
      end
      checks++;
      if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: got req_valid=%b instr_valid=%b required 0/1", s_req_valid,
                  s_instr_valid);
      end
      got   = 1'b0;
      first = 32'h0;
      pops  = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (s_req_valid && !got) begin
            got   = 1'b1;
            first = s_req_addr;
         end
         if (s_pop) pops++;
      end
      checks++;
      if (!got || first !== 32'h10) begin
         errors++;
         $display("FAIL bp_resume: got seen=%b addr=%h required 1/00000010", got, first);
      end
      checks++;
      if (pops < 4) begin
         errors++;
         $display("FAIL bp_drain: got %0d pops required >= 4", pops);
      end
   endtask

   task automatic test_redirect();
      bit          got;
      logic [31:0] first;
      do_reset();
      lat = 3;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'h103);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL redirect_req: got v=%b addr=%h required 1/00000100", s_req_valid,
                  s_req_addr);
      end
      got   = 1'b0;
      first = 32'h0;
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (s_pop && !got) begin
            got   = 1'b1;
            first = s_instr_pc;
         end
      end
      checks++;
      if (!got || first !== 32'h100) begin
         errors++;
         $display("FAIL redirect_first_pc: got seen=%b pc=%h required 1/00000100", got, first);
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      lat = 2;
      cycle(1'b0, 1'b1, 1'b1, 32'h20);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0);
         checks++;
         if (s_req_valid !== 1'b1 || s_req_addr !== 32'h20) begin
            errors++;
            $display("FAIL req_hold: cycle %0d got v=%b addr=%h required 1/00000020", i,
                     s_req_valid, s_req_addr);
         end
      end
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_pc_wrap();
      logic [31:0] ea;
      w_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      w_rst = 1'b0;
      ea    = 32'hFFFF_FFF8;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (w_req_valid !== 1'b1 || w_req_addr !== ea) begin
            errors++;
            $display("FAIL pc_wrap: req %0d got v=%b addr=%h required 1/%h", i, w_req_valid,
                     w_req_addr, ea);
         end
         ea = ea + 32'd4;
         @(negedge clk);
      end
      w_rst = 1'b1;
   endtask

   task automatic test_mid_reset();
      do_reset();
      lat = 1;
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_f(32'h0)) begin
         errors++;
         $display("FAIL pre_reset_head: got v=%b pc=%h instr=%h required 1/00000000/%h",
                  instr_valid, instr_pc, instr, mem_f(32'h0));
      end
      // Reset arrives together with the last outstanding response.
      rst            = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(32'hC);
      instr_ready    = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got v=%b instr=%h pc=%h required 0/0/0",
                  instr_valid, instr, instr_pc);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetched !== 32'h0 || perf_redirects !== 32'h0 || perf_stall !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_perf: got %h %h %h required 0", perf_fetched,
                  perf_redirects, perf_stall);
      end
`endif
      rst            = 1'b0;
      imem_rsp_valid = 1'b0;
      init_model();
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_first_req: got v=%b addr=%h required 1/00000000",
                  imem_req_valid, imem_req_addr);
      end
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (n_pop < 10) begin
         errors++;
         $display("FAIL mid_reset_restart: got %0d pops required >= 10", n_pop);
      end
   endtask

   task automatic test_random();
      bit          rq, ir, rd;
      logic [31:0] tgt;
      do_reset();
      lat = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) lat = int'($urandom_range(1, 4));
         rq  = ($urandom_range(0, 9) < 7);
         ir  = ($urandom_range(0, 9) < 6);
         rd  = ($urandom_range(0, 49) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(rq, ir, rd, tgt);
      end
      checks++;
      if (n_pop < 500) begin
         errors++;
         $display("FAIL random_progress: got %0d pops required >= 500", n_pop);
      end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (perf_fetched !== 32'(n_pop) || perf_redirects !== 32'(n_redir)
          || perf_stall !== 32'(n_stall)) begin
         errors++;
         $display("FAIL perf_counts: got %0d %0d %0d required %0d %0d %0d", perf_fetched,
                  perf_redirects, perf_stall, n_pop, n_redir, n_stall);
      end
`endif
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      cyc              = 0;
      lat              = 1;
      rst              = 1'b1;
      imem_req_ready   = 1'b0;
      imem_rsp_valid   = 1'b0;
      imem_rsp_data    = 32'h0;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'h0;
      instr_ready      = 1'b0;
      w_rst            = 1'b1;
      w_req_ready      = 1'b1;
      w_rsp_valid      = 1'b0;
      w_rsp_data       = 32'h0;
      w_redirect_valid = 1'b0;
      w_redirect_pc    = 32'h0;
      w_instr_ready    = 1'b0;
      init_model();
      test_reset();
      test_in_order();
      test_backpressure();
      test_redirect();
      test_req_stall();
      test_pc_wrap();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
